fifo_mem_ctrl: RTL and testbench

- Multi-lane circular-FIFO controller. It owns the head/tail pointers and occupancy, and drives the read/write port signals of an external multi-port register-array memory.
- The memory reads combinationally (no bypass) and writes at posedge; its read data returns to this block.
- Used for tag queues in the out-of-order core, e.g. the free list and the retire-tag queue.

---
 rtl/fifo_pkg.sv | 27 ++
 rtl/fifo_mem_ctrl_if.sv | 42 ++++
 rtl/fifo_lane_grant.sv | 24 ++
 rtl/fifo_mem_ctrl.sv | 135 +++++++++++++
 tb/tb_fifo_mem_ctrl.sv | 208 ++++++++++++++++++++
 5 files changed

// File: rtl/fifo_pkg.sv
// Shared types and helpers for the multi-lane circular FIFO controller.
// Holds default geometry, the pointer type for the default geometry, and a
// lane-grant population count used to advance head/tail/count.
package fifo_pkg;

  localparam int DEFAULT_WIDTH = 32;
  localparam int DEFAULT_DEPTH = 32;
  localparam int DEFAULT_CNT_W = $clog2(DEFAULT_DEPTH) + 1;

  // Upper bound on lanes per side; grant vectors are zero-extended to this.
  localparam int MAX_LANES  = 8;
  localparam int LANE_CNT_W = $clog2(MAX_LANES + 1);

  // Pointer/occupancy for the default depth; MSB is the wrap bit.
  typedef logic [DEFAULT_CNT_W-1:0] fifo_ptr_t;

  // Number of set grant bits.
  function automatic logic [LANE_CNT_W-1:0] popcnt_lanes(input logic [MAX_LANES-1:0] lanes);
    logic [LANE_CNT_W-1:0] n;
    n = '0;
    for (int i = 0; i < MAX_LANES; i++) begin
      n = n + LANE_CNT_W'(lanes[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/fifo_mem_ctrl_if.sv
// Request/grant and external-memory port bundle for fifo_mem_ctrl.
// Latency: n/a (wires only). Backpressure: grants are the only flow control.
// Ports: push_req/push_data/push_gnt, pop_req/pop_gnt/pop_data,
//        mem_re/mem_raddr/mem_rdata, mem_we/mem_waddr/mem_wdata.
//        slave = controller side, master = client + memory side.
interface fifo_mem_ctrl_if #(
  parameter int WIDTH       = 32,
  parameter int DEPTH       = 32,
  parameter int READ_PORTS  = 2,
  parameter int WRITE_PORTS = 1
);
  localparam int AW = $clog2(DEPTH);

  logic [WRITE_PORTS-1:0]            push_req;
  logic [WRITE_PORTS-1:0][WIDTH-1:0] push_data;
  logic [WRITE_PORTS-1:0]            push_gnt;

  logic [READ_PORTS-1:0]             pop_req;
  logic [READ_PORTS-1:0]             pop_gnt;
  logic [READ_PORTS-1:0][WIDTH-1:0]  pop_data;

  logic [READ_PORTS-1:0]             mem_re;
  logic [READ_PORTS-1:0][AW-1:0]     mem_raddr;
  logic [READ_PORTS-1:0][WIDTH-1:0]  mem_rdata;

  logic [WRITE_PORTS-1:0]            mem_we;
  logic [WRITE_PORTS-1:0][AW-1:0]    mem_waddr;
  logic [WRITE_PORTS-1:0][WIDTH-1:0] mem_wdata;

  modport slave (
    input  push_req, push_data, pop_req, mem_rdata,
    output push_gnt, pop_gnt, pop_data,
           mem_re, mem_raddr, mem_we, mem_waddr, mem_wdata
  );

  modport master (
    output push_req, push_data, pop_req, mem_rdata,
    input  push_gnt, pop_gnt, pop_data,
           mem_re, mem_raddr, mem_we, mem_waddr, mem_wdata
  );

endinterface

// File: rtl/fifo_lane_grant.sv
// Contiguous-request lane grant generator: lane i granted iff req[0..i] all set and i < limit.
// Latency: combinational, 0 cycles.
// Backpressure: limit (occupancy or free space) caps grants; a gap in req blocks every lane above it.
module fifo_lane_grant #(
  parameter int LANES = 2,
  parameter int CNT_W = 6
) (
  input  logic [LANES-1:0] req,
  input  logic [CNT_W-1:0] limit,
  output logic [LANES-1:0] gnt
);

  always_comb begin
    logic run;
    run = 1'b1;
    gnt = '0;
    for (int i = 0; i < LANES; i++) begin
      // run drops at the first unset request and stays low, so a gap kills upper lanes.
      run    = run & req[i];
      gnt[i] = run && (CNT_W'(i) < limit);
    end
  end

endmodule

// File: rtl/fifo_mem_ctrl.sv
// Multi-lane circular FIFO controller driving an external combinational-read register array.
// Latency: pop data same cycle as grant; pushed entry poppable the next cycle.
// Backpressure: pop grants capped by occupancy, push grants by free space (no fall-through); flush blocks all.
// Ports: clock, reset (sync, active-high), flush, count/full/empty, bus (fifo_mem_ctrl_if.slave).
// Optional: FIFO_CKPT_EN adds ckpt_save/ckpt_restore for head checkpoint and mispredict recovery.
module fifo_mem_ctrl
  import fifo_pkg::*;
#(
  parameter int WIDTH       = DEFAULT_WIDTH,
  parameter int DEPTH       = DEFAULT_DEPTH,
  parameter int READ_PORTS  = 2,
  parameter int WRITE_PORTS = 1,
  parameter int CNT_W       = $clog2(DEPTH) + 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             flush,
`ifdef FIFO_CKPT_EN
  input  logic             ckpt_save,
  input  logic             ckpt_restore,
`endif
  fifo_mem_ctrl_if.slave   bus,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [CNT_W-1:0] head, tail, cnt;
  logic [CNT_W-1:0] space;
  logic [CNT_W-1:0] n_pop, n_push;
  logic [CNT_W-1:0] head_upd, tail_upd, cnt_upd;

  logic                   block_all, block_pop;
  logic [READ_PORTS-1:0]  pop_req_m, pop_gnt;
  logic [WRITE_PORTS-1:0] push_req_m, push_gnt;

  // Reset cycle also reports no grants, so nothing is written while state is being cleared.
  assign block_all = flush | reset;
`ifdef FIFO_CKPT_EN
  // A restore rewinds head, so popping in the same cycle would be lost.
  assign block_pop = block_all | ckpt_restore;
`else
  assign block_pop = block_all;
`endif

  assign pop_req_m  = block_pop ? '0 : bus.pop_req;
  assign push_req_m = block_all ? '0 : bus.push_req;

  // Space comes from start-of-cycle occupancy only: same-cycle pops do not free slots.
  assign space = CNT_W'(DEPTH) - cnt;

  fifo_lane_grant #(.LANES(READ_PORTS), .CNT_W(CNT_W)) u_pop_grant (
    .req   (pop_req_m),
    .limit (cnt),
    .gnt   (pop_gnt)
  );

  fifo_lane_grant #(.LANES(WRITE_PORTS), .CNT_W(CNT_W)) u_push_grant (
    .req   (push_req_m),
    .limit (space),
    .gnt   (push_gnt)
  );

  assign n_pop    = CNT_W'(popcnt_lanes(MAX_LANES'(pop_gnt)));
  assign n_push   = CNT_W'(popcnt_lanes(MAX_LANES'(push_gnt)));
  assign head_upd = head + n_pop;
  assign tail_upd = tail + n_push;
  assign cnt_upd  = cnt + n_push - n_pop;

  // Memory-side and client-side outputs.
  always_comb begin
    bus.pop_gnt   = pop_gnt;
    bus.mem_re    = pop_gnt;
    bus.push_gnt  = push_gnt;
    bus.mem_we    = push_gnt;
    bus.mem_raddr = '0;
    bus.pop_data  = '0;
    bus.mem_waddr = '0;
    bus.mem_wdata = '0;
    for (int i = 0; i < READ_PORTS; i++) begin
      bus.mem_raddr[i] = head[AW-1:0] + AW'(i);
      bus.pop_data[i]  = pop_gnt[i] ? bus.mem_rdata[i] : '0;
    end
    for (int j = 0; j < WRITE_PORTS; j++) begin
      bus.mem_waddr[j] = tail[AW-1:0] + AW'(j);
      bus.mem_wdata[j] = bus.push_data[j];
    end
  end

`ifdef FIFO_CKPT_EN
  logic [CNT_W-1:0] ckpt_head;

  always_ff @(posedge clock) begin
    if (reset || flush) begin
      head      <= '0;
      tail      <= '0;
      cnt       <= '0;
      ckpt_head <= '0;
    end else begin
      tail <= tail_upd;
      if (ckpt_restore) begin
        // Entries popped since the save are still in memory; re-expose them.
        head <= ckpt_head;
        cnt  <= tail_upd - ckpt_head;
      end else begin
        head <= head_upd;
        cnt  <= cnt_upd;
        if (ckpt_save) begin
          ckpt_head <= head_upd;
        end
      end
    end
  end
`else
  always_ff @(posedge clock) begin
    if (reset || flush) begin
      head <= '0;
      tail <= '0;
      cnt  <= '0;
    end else begin
      head <= head_upd;
      tail <= tail_upd;
      cnt  <= cnt_upd;
    end
  end
`endif

  // Occupancy flags come from count, never from comparing pointers.
  assign count = cnt;
  assign full  = (cnt == CNT_W'(DEPTH));
  assign empty = (cnt == '0);

endmodule

// File: tb/tb_fifo_mem_ctrl.sv
// Directed bench for fifo_mem_ctrl with a queue scoreboard and a behavioural register-array memory.
// Latency: expects 0-cycle pop data and 1-cycle push-to-pop visibility.
// Backpressure: expected grants come from a bench-side occupancy model; FIFO_CKPT_EN enables the checkpoint steps.
module tb_fifo_mem_ctrl;
  import fifo_pkg::*;

  localparam int WIDTH = 32;
  localparam int DEPTH = 32;
  localparam int RP    = 2;
  localparam int WP    = 1;
  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int AW    = $clog2(DEPTH);

  logic             clock = 1'b0;
  logic             reset;
  logic             flush;
  logic [CNT_W-1:0] count;
  logic             full, empty;
`ifdef FIFO_CKPT_EN
  logic             ckpt_save    = 1'b0;
  logic             ckpt_restore = 1'b0;
  fifo_ptr_t        m_ckpt       = '0;
  logic [WIDTH-1:0] mm [DEPTH];
`endif

  int tests = 0;
  int fails = 0;

  fifo_ptr_t        m_head = '0, m_tail = '0, m_count = '0;
  logic [WIDTH-1:0] q [$];
  logic [WIDTH-1:0] mem [DEPTH];

  fifo_mem_ctrl_if #(.WIDTH(WIDTH), .DEPTH(DEPTH), .READ_PORTS(RP), .WRITE_PORTS(WP)) bus ();

  fifo_mem_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH), .READ_PORTS(RP), .WRITE_PORTS(WP)) dut (
    .clock        (clock),
    .reset        (reset),
    .flush        (flush),
`ifdef FIFO_CKPT_EN
    .ckpt_save    (ckpt_save),
    .ckpt_restore (ckpt_restore),
`endif
    .bus          (bus),
    .count        (count),
    .full         (full),
    .empty        (empty)
  );

  always #5 clock = ~clock;

  // External register array: combinational read, write at posedge.
  always @(posedge clock) begin
    if (bus.mem_we[0]) mem[bus.mem_waddr[0]] <= bus.mem_wdata[0];
  end
  always_comb begin
    for (int i = 0; i < RP; i++) bus.mem_rdata[i] = mem[bus.mem_raddr[i]];
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock of stimulus: drive, compare combinational outputs against the model, advance.
  task automatic cycle(input logic pe, input logic [WIDTH-1:0] pd, input logic [1:0] pr, input logic fl);
    logic [1:0]       eo;
    logic             ep;
    logic             rs;
    logic [WIDTH-1:0] exp_d;
    fifo_ptr_t        np;
    bus.push_req     = pe;
    bus.push_data[0] = pd;
    bus.pop_req      = pr;
    flush            = fl;
    #1;
    rs = 1'b0;
`ifdef FIFO_CKPT_EN
    rs = ckpt_restore;
`endif
    eo[0] = pr[0] && (m_count > 0) && !fl && !rs;
    eo[1] = pr[0] && pr[1] && (m_count > 1) && !fl && !rs;
    ep    = pe && (m_count < DEPTH) && !fl;

    chk("count", 64'(count), 64'(m_count));
    chk("empty", 64'(empty), 64'(m_count == 0));
    chk("full", 64'(full), 64'(m_count == DEPTH));
    chk("pop_gnt", 64'(bus.pop_gnt), 64'(eo));
    chk("mem_re", 64'(bus.mem_re), 64'(eo));
    chk("push_gnt", 64'(bus.push_gnt), 64'(ep));
    chk("mem_we", 64'(bus.mem_we), 64'(ep));
    chk("mem_waddr", 64'(bus.mem_waddr[0]), 64'(m_tail[AW-1:0]));
    chk("mem_wdata", 64'(bus.mem_wdata[0]), 64'(pd));
    for (int i = 0; i < RP; i++) begin
      chk("mem_raddr", 64'(bus.mem_raddr[i]), 64'(AW'(m_head + fifo_ptr_t'(i))));
      if (eo[i]) begin
        exp_d = q.pop_front();
        chk("pop_data", 64'(bus.pop_data[i]), 64'(exp_d));
      end else begin
        chk("pop_data_idle", 64'(bus.pop_data[i]), 64'd0);
      end
    end

    if (ep) begin
      q.push_back(pd);
`ifdef FIFO_CKPT_EN
      mm[m_tail[AW-1:0]] = pd;
`endif
    end
    np = fifo_ptr_t'(eo[0]) + fifo_ptr_t'(eo[1]);
    if (fl) begin
      m_head = '0; m_tail = '0; m_count = '0;
      q.delete();
`ifdef FIFO_CKPT_EN
      m_ckpt = '0;
`endif
    end else begin
      m_head  = m_head + np;
      m_tail  = m_tail + fifo_ptr_t'(ep);
      m_count = m_count + fifo_ptr_t'(ep) - np;
`ifdef FIFO_CKPT_EN
      if (rs) begin
        m_head  = m_ckpt;
        m_count = m_tail - m_ckpt;
        q.delete();
        for (int k = 0; k < int'(m_count); k++) q.push_back(mm[AW'(m_ckpt + fifo_ptr_t'(k))]);
      end else if (ckpt_save) begin
        m_ckpt = m_head;
      end
`endif
    end
    @(posedge clock);
    #1;
  endtask

  initial begin
    // Reset with requests active: nothing may be granted or written.
    reset            = 1'b1;
    flush            = 1'b0;
    bus.push_req     = 1'b1;
    bus.push_data[0] = 32'hDEAD;
    bus.pop_req      = 2'b11;
    @(posedge clock);
    #1;
    chk("rst_push_gnt", 64'(bus.push_gnt), 64'd0);
    chk("rst_mem_we", 64'(bus.mem_we), 64'd0);
    chk("rst_pop_gnt", 64'(bus.pop_gnt), 64'd0);
    chk("rst_mem_re", 64'(bus.mem_re), 64'd0);
    chk("rst_pop_data", 64'(bus.pop_data), 64'd0);
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_empty", 64'(empty), 64'd1);
    chk("rst_full", 64'(full), 64'd0);
    @(posedge clock);
    #1;
    reset = 1'b0;

    // Single push then pop on the next cycle.
    cycle(1'b1, 32'hA5, 2'b00, 1'b0);
    cycle(1'b0, 32'h0, 2'b01, 1'b0);
    cycle(1'b0, 32'h0, 2'b00, 1'b0);

    // Fill to full, then push + dual pop: push refused, two oldest popped.
    for (int k = 0; k < DEPTH; k++) cycle(1'b1, WIDTH'(k), 2'b00, 1'b0);
    cycle(1'b1, 32'hFF, 2'b11, 1'b0);
    for (int k = 0; k < (DEPTH - 2) / 2; k++) cycle(1'b0, 32'h0, 2'b11, 1'b0);
    cycle(1'b0, 32'h0, 2'b00, 1'b0);

    // Stream 40 single entries so pointers wrap; full must stay low.
    for (int k = 0; k < 40; k++) cycle(1'b1, WIDTH'(32'h200 + k), (k == 0) ? 2'b00 : 2'b01, 1'b0);
    cycle(1'b0, 32'h0, 2'b01, 1'b0);

    // One entry with both lanes requested: only lane 0 granted.
    cycle(1'b1, 32'h300, 2'b00, 1'b0);
    cycle(1'b0, 32'h0, 2'b11, 1'b0);
    // Gap in the request vector: lane 1 alone never granted.
    cycle(1'b1, 32'h301, 2'b00, 1'b0);
    cycle(1'b1, 32'h302, 2'b00, 1'b0);
    cycle(1'b0, 32'h0, 2'b10, 1'b0);
    cycle(1'b0, 32'h0, 2'b11, 1'b0);

    // Flush with 5 entries and active push/pop.
    for (int k = 0; k < 5; k++) cycle(1'b1, WIDTH'(32'h400 + k), 2'b00, 1'b0);
    cycle(1'b1, 32'h4FF, 2'b11, 1'b1);
    cycle(1'b0, 32'h0, 2'b00, 1'b0);

`ifdef FIFO_CKPT_EN
    // Push 8, save, pop 3, restore: all 8 visible again, oldest first.
    for (int k = 0; k < 8; k++) cycle(1'b1, WIDTH'(32'h100 + k), 2'b00, 1'b0);
    ckpt_save = 1'b1;
    cycle(1'b0, 32'h0, 2'b00, 1'b0);
    ckpt_save = 1'b0;
    cycle(1'b0, 32'h0, 2'b11, 1'b0);
    cycle(1'b0, 32'h0, 2'b01, 1'b0);
    ckpt_restore = 1'b1;
    cycle(1'b0, 32'h0, 2'b11, 1'b0);
    ckpt_restore = 1'b0;
    chk("ckpt_count", 64'(count), 64'd8);
    cycle(1'b0, 32'h0, 2'b01, 1'b0);
    chk("ckpt_first_pop_seen", 64'(q.size()), 64'd7);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
